// File: rtl/alarm_controller_pkg.sv
// alarm_controller_pkg: state encodings and helpers shared by the alarm controller and its bench
package alarm_controller_pkg;
  typedef enum logic [2:0] {
    ST_DISARMED  = 3'd0,
    ST_EXIT_DLY  = 3'd1,
    ST_ARMED     = 3'd2,
    ST_ENTRY_DLY = 3'd3,
    ST_ALARM     = 3'd4
  } state_t;
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/alarm_timer.sv
// alarm_timer: saturating down-counter; ports load/load_val set it, dec steps it, count/zero report it
module alarm_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign count = cnt_q;
  assign zero  = (cnt_q == '0);
endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: armed/disarmed zone monitor with exit/entry delays, sticky trips, panic; drives Alarm, armed, state, tripped, countdown
module alarm_controller
  import alarm_controller_pkg::*;
#(
  parameter int                 N_ZONES     = 3,
  parameter int                 EXIT_DELAY  = 8,
  parameter int                 ENTRY_DELAY = 4,
  parameter logic [N_ZONES-1:0] ENTRY_MASK  = 3'b010,
  parameter int                 CNT_W       = $clog2(max_int(EXIT_DELAY, ENTRY_DELAY) + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Panic,
  input  logic               Enable,
  input  logic               Exiting,
  input  logic [N_ZONES-1:0] zone_ok,
  output logic               Alarm,
  output logic               armed,
  output logic [2:0]         state,
  output logic [N_ZONES-1:0] tripped,
  output logic [CNT_W-1:0]   countdown
);
  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DELAY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DELAY - 1);
  state_t state_q, state_d;
  logic [N_ZONES-1:0] trip_q, trip_d, opn, imm, ent, trip_base;
  logic alarm_q, alarm_d, armed_q, armed_d;
  logic tm_load, tm_dec, tm_zero;
  logic [CNT_W-1:0] tm_val, cnt;
  assign opn = ~zone_ok;
  assign imm = opn & ~ENTRY_MASK;
  assign ent = opn & ENTRY_MASK;
  // while alarming, open zones accumulate every cycle regardless of the transition taken
  assign trip_base = (state_q == ST_ALARM) ? (trip_q | opn) : trip_q;
  alarm_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk), .reset(reset), .load(tm_load), .load_val(tm_val),
    .dec(tm_dec), .count(cnt), .zero(tm_zero)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_DISARMED;
      trip_q  <= '0;
      alarm_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      trip_q  <= trip_d;
      alarm_q <= alarm_d;
      armed_q <= armed_d;
    end
  end
  always_comb begin
    state_d = state_q;
    trip_d  = trip_base;
    tm_load = 1'b0;
    tm_val  = '0;
    tm_dec  = 1'b0;
    if (Panic) begin
      state_d = ST_ALARM;
      tm_load = 1'b1;
    end else if (!Enable) begin
      state_d = ST_DISARMED;
      tm_load = 1'b1;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          state_d = ST_EXIT_DLY;
          tm_load = 1'b1;
          tm_val  = EXIT_LD;
          trip_d  = '0;
        end
        ST_EXIT_DLY: begin
          if (Exiting) begin
            tm_load = 1'b1;
            tm_val  = EXIT_LD;
          end else if (tm_zero) begin
            state_d = (|opn) ? ST_ALARM : ST_ARMED;
            trip_d  = trip_q | opn;
          end else tm_dec = 1'b1;
        end
        ST_ARMED: begin
          if (|imm) begin
            state_d = ST_ALARM;
            trip_d  = trip_q | opn;
          end else if (|ent) begin
            state_d = ST_ENTRY_DLY;
            tm_load = 1'b1;
            tm_val  = ENTRY_LD;
            trip_d  = trip_q | opn;
          end
        end
        ST_ENTRY_DLY: begin
          if ((|imm) || tm_zero) begin
            state_d = ST_ALARM;
            tm_load = 1'b1;
            trip_d  = trip_q | opn;
          end else tm_dec = 1'b1;
        end
        ST_ALARM: state_d = ST_ALARM;
        default: begin
          state_d = ST_DISARMED;
          tm_load = 1'b1;
        end
      endcase
    end
  end
  always_comb begin
    alarm_d = (state_d == ST_ALARM);
    armed_d = (state_d == ST_ARMED) || (state_d == ST_ENTRY_DLY);
  end
  assign Alarm     = alarm_q;
  assign armed     = armed_q;
  assign state     = state_q;
  assign tripped   = trip_q;
  assign countdown = cnt;
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: scoreboard bench comparing alarm_controller against a cycle model
module tb_alarm_controller;
  import alarm_controller_pkg::*;
  localparam logic [2:0] MASK = 3'b010;
  logic clk = 1'b0;
  logic reset = 1'b1, Panic = 1'b0, Enable = 1'b0, Exiting = 1'b0;
  logic [2:0] zone_ok = 3'b000;
  logic Alarm, armed;
  logic [2:0] state, tripped, countdown;
  typedef struct packed {
    logic [2:0] st;
    logic       al;
    logic       ar;
    logic [2:0] tr;
    logic [2:0] cn;
  } exp_t;
  exp_t sb[$];
  int n_run = 0, n_fail = 0, cyc = 0;
  int m_st = 0, m_cnt = 0;
  logic [2:0] m_trip = 3'b000;
  always #5 clk = ~clk;
  alarm_controller #(
    .N_ZONES(3), .EXIT_DELAY(4), .ENTRY_DELAY(3), .ENTRY_MASK(3'b010)
  ) dut (
    .clk(clk), .reset(reset), .Panic(Panic), .Enable(Enable), .Exiting(Exiting),
    .zone_ok(zone_ok), .Alarm(Alarm), .armed(armed), .state(state),
    .tripped(tripped), .countdown(countdown)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic r, input logic p, input logic en, input logic ex, input logic [2:0] z);
    logic [2:0] o;
    int ns, nc;
    o  = ~z;
    ns = m_st;
    nc = m_cnt;
    if (r) begin
      ns = 0; nc = 0; m_trip = 3'b000;
    end else begin
      if (m_st == 4) m_trip = m_trip | o;
      if (p) begin
        ns = 4; nc = 0;
      end else if (!en) begin
        ns = 0; nc = 0;
      end else if (m_st == 0) begin
        ns = 1; nc = 3; m_trip = 3'b000;
      end else if (m_st == 1) begin
        if (ex) nc = 3;
        else if (nc == 0) begin
          ns = (o != 0) ? 4 : 2;
          m_trip = m_trip | o;
        end else nc = nc - 1;
      end else if (m_st == 2) begin
        if ((o & ~MASK) != 0) begin
          ns = 4; m_trip = m_trip | o;
        end else if ((o & MASK) != 0) begin
          ns = 3; nc = 2; m_trip = m_trip | o;
        end
      end else if (m_st == 3) begin
        if ((o & ~MASK) != 0 || nc == 0) begin
          ns = 4; nc = 0; m_trip = m_trip | o;
        end else nc = nc - 1;
      end
    end
    m_st  = ns;
    m_cnt = nc;
  endtask
  task automatic step(input logic r, input logic p, input logic en, input logic ex, input logic [2:0] z);
    exp_t e;
    @(negedge clk);
    reset = r; Panic = p; Enable = en; Exiting = ex; zone_ok = z;
    model(r, p, en, ex, z);
    e.st = 3'(m_st);
    e.al = (m_st == 4);
    e.ar = (m_st == 2) || (m_st == 3);
    e.tr = m_trip;
    e.cn = 3'(m_cnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    chk($sformatf("state@%0d", cyc), 32'(state), 32'(e.st));
    chk($sformatf("Alarm@%0d", cyc), 32'(Alarm), 32'(e.al));
    chk($sformatf("armed@%0d", cyc), 32'(armed), 32'(e.ar));
    chk($sformatf("tripped@%0d", cyc), 32'(tripped), 32'(e.tr));
    chk($sformatf("countdown@%0d", cyc), 32'(countdown), 32'(e.cn));
  endtask
  task automatic arm_clean();
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 3'b111);
  endtask
  initial begin
    int n_exit;
    step(1, 0, 0, 0, 3'b000);
    step(1, 0, 0, 0, 3'b000);
    chk("reset_state", 32'(state), 32'(ST_DISARMED));
    chk("reset_tripped", 32'(tripped), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 3'b000);
    chk("idle_alarm", 32'(Alarm), 0);
    n_exit = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 3'b111);
      if (state == 3'(ST_EXIT_DLY)) n_exit++;
    end
    chk("exit_len", 32'(n_exit), 4);
    chk("armed_after_exit", 32'(armed), 1);
    step(0, 0, 1, 0, 3'b101);
    chk("entry_state", 32'(state), 32'(ST_ENTRY_DLY));
    chk("entry_tripped", 32'(tripped), 32'(3'b010));
    step(0, 0, 0, 0, 3'b101);
    chk("entry_disarm", 32'(state), 32'(ST_DISARMED));
    arm_clean();
    chk("rearm_trip_clear", 32'(tripped), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 3'b101);
    chk("entry_not_yet", 32'(Alarm), 0);
    step(0, 0, 1, 0, 3'b101);
    chk("entry_4th_edge", 32'(Alarm), 1);
    step(0, 0, 0, 0, 3'b111);
    arm_clean();
    step(0, 0, 1, 0, 3'b110);
    chk("window_alarm", 32'(Alarm), 1);
    chk("window_tripped", 32'(tripped), 32'(3'b001));
    step(0, 0, 1, 0, 3'b111);
    step(0, 0, 1, 0, 3'b111);
    chk("alarm_latched", 32'(Alarm), 1);
    step(0, 0, 0, 0, 3'b111);
    chk("alarm_cleared", 32'(Alarm), 0);
    chk("trip_held", 32'(tripped), 32'(3'b001));
    step(0, 1, 0, 0, 3'b111);
    chk("panic_disarmed", 32'(Alarm), 1);
    step(0, 0, 0, 0, 3'b111);
    chk("panic_release", 32'(state), 32'(ST_DISARMED));
    step(0, 1, 1, 0, 3'b111);
    step(0, 0, 1, 0, 3'b111);
    step(0, 0, 1, 0, 3'b111);
    chk("panic_enabled_hold", 32'(state), 32'(ST_ALARM));
    step(0, 0, 0, 0, 3'b111);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 3'b111);
    chk("cd_before_exiting", 32'(countdown), 1);
    step(0, 0, 1, 1, 3'b111);
    chk("cd_reload", 32'(countdown), 3);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 3'b011);
    chk("garage_alarm", 32'(state), 32'(ST_ALARM));
    chk("garage_tripped", 32'(tripped), 32'(3'b100));
    step(0, 0, 0, 0, 3'b111);
    step(0, 0, 1, 0, 3'b111);
    step(0, 0, 1, 0, 3'b111);
    step(1, 0, 1, 0, 3'b011);
    chk("mid_exit_reset_state", 32'(state), 32'(ST_DISARMED));
    chk("mid_exit_reset_cd", 32'(countdown), 0);
    for (int i = 0; i < 80; i++)
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b111);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
